// File: rtl/moldudp64_hdr_parser.sv
`default_nettype none
// ============================================================================
// Module   : moldudp64_hdr_parser
// Purpose  : Strips Eth/(802.1Q)/IPv4/UDP/MoldUDP64 headers and emits framed
//            MoldUDP64 message payloads with per-message sequence numbers.
//            Optional macro VLAN_EN enables single-tag 802.1Q parsing.
// Revision : 1.0 - initial release
// ============================================================================
module moldudp64_hdr_parser #(
    parameter logic [15:0] UDP_PORT    = 16'd0,
    parameter logic [15:0] MAX_MSG_LEN = 16'd1024,
    parameter logic [2:0]  FCS_BYTES   = 3'd4
) (
    input  logic        clkIn,
    input  logic        rstIn,
    input  logic [7:0]  dataIn,
    input  logic        dataValidIn,
    input  logic        dataLastIn,
    output logic [7:0]  msgDataOut,
    output logic        msgValidOut,
    output logic        msgStartOut,
    output logic        msgLastOut,
    output logic [63:0] seqNumOut,
    output logic        dropOut,
    output logic        errOut
);
    localparam int c_FCS = int'(FCS_BYTES);

    localparam logic [3:0] c_ETH   = 4'd0;
`ifdef VLAN_EN
    localparam logic [3:0] c_VLAN  = 4'd1;
`endif
    localparam logic [3:0] c_IP    = 4'd2;
    localparam logic [3:0] c_UDP   = 4'd3;
    localparam logic [3:0] c_MOLD  = 4'd4;
    localparam logic [3:0] c_MLEN  = 4'd5;
    localparam logic [3:0] c_MDATA = 4'd6;
    localparam logic [3:0] c_TAIL  = 4'd7;
    localparam logic [3:0] c_SKIP  = 4'd8;

    logic [7:0]  w_pByte;
    logic        w_pValid;
    logic        w_endNoByte;
    logic [3:0]  r_state, w_nextState, w_natNext;
    logic [15:0] r_byteCnt, r_msgRemain, r_msgLen;
    logic [7:0]  r_prevByte;
    logic [5:0]  r_hdrLen;
    logic [63:0] r_seq;
    logic        w_dropHit, w_errHit, w_truncErr, w_cntClr, w_msgDone;
    logic        w_msgValid, w_msgStart, w_msgLast;
    logic [15:0] w_field;

    assign w_field = {r_prevByte, w_pByte};

    // A byte is released to the parser only once FCS_BYTES newer bytes exist.
    generate
        if (c_FCS == 0) begin : g_noFcs
            assign w_pByte     = dataIn;
            assign w_pValid    = dataValidIn;
            assign w_endNoByte = 1'b0;
        end else begin : g_fcs
            logic [c_FCS*8-1:0] r_dly;
            logic [3:0]         r_fill;
            assign w_pByte     = r_dly[c_FCS*8-1 -: 8];
            assign w_pValid    = dataValidIn && (r_fill == 4'(c_FCS));
            assign w_endNoByte = dataValidIn && dataLastIn && !w_pValid;
            always_ff @(posedge clkIn or posedge rstIn) begin
                if (rstIn) begin
                    r_dly  <= '0;
                    r_fill <= '0;
                end else if (dataValidIn) begin
                    r_dly <= (c_FCS*8)'({r_dly, dataIn});
                    if (dataLastIn)
                        r_fill <= '0;
                    else if (r_fill != 4'(c_FCS))
                        r_fill <= r_fill + 4'd1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) r_state <= c_ETH;
        else       r_state <= w_nextState;
    end

    always_comb begin
        w_natNext  = r_state;
        w_dropHit  = 1'b0;
        w_errHit   = 1'b0;
        w_cntClr   = 1'b0;
        w_msgDone  = 1'b0;
        w_truncErr = 1'b0;
        if (w_pValid) begin
            case (r_state)
                c_ETH: if (r_byteCnt == 16'd13) begin
                    w_cntClr = 1'b1;
                    if (w_field == 16'h0800) w_natNext = c_IP;
`ifdef VLAN_EN
                    else if (w_field == 16'h8100) w_natNext = c_VLAN;
`endif
                    else begin w_natNext = c_SKIP; w_dropHit = 1'b1; end
                end
`ifdef VLAN_EN
                c_VLAN: if (r_byteCnt == 16'd3) begin
                    w_cntClr = 1'b1;
                    if (w_field == 16'h0800) w_natNext = c_IP;
                    else begin w_natNext = c_SKIP; w_dropHit = 1'b1; end
                end
`endif
                c_IP: begin
                    if (r_byteCnt == 16'd0) begin
                        if (w_pByte[7:4] != 4'd4) begin
                            w_natNext = c_SKIP; w_dropHit = 1'b1; w_cntClr = 1'b1;
                        end else if (w_pByte[3:0] < 4'd5) begin
                            w_natNext = c_SKIP; w_errHit = 1'b1; w_cntClr = 1'b1;
                        end
                    end else if (r_byteCnt == 16'd9 && w_pByte != 8'd17) begin
                        w_natNext = c_SKIP; w_dropHit = 1'b1; w_cntClr = 1'b1;
                    end else if (r_byteCnt == {10'd0, r_hdrLen} - 16'd1) begin
                        w_natNext = c_UDP; w_cntClr = 1'b1;
                    end
                end
                c_UDP: begin
                    if (r_byteCnt == 16'd3 && UDP_PORT != 16'd0 && w_field != UDP_PORT) begin
                        w_natNext = c_SKIP; w_dropHit = 1'b1; w_cntClr = 1'b1;
                    end else if (r_byteCnt == 16'd7) begin
                        w_natNext = c_MOLD; w_cntClr = 1'b1;
                    end
                end
                c_MOLD: if (r_byteCnt == 16'd19) begin
                    w_cntClr  = 1'b1;
                    w_natNext = (w_field == 16'h0000 || w_field == 16'hFFFF) ? c_TAIL : c_MLEN;
                end
                c_MLEN: if (r_byteCnt == 16'd1) begin
                    w_cntClr = 1'b1;
                    if (w_field > MAX_MSG_LEN) begin
                        w_natNext = c_SKIP; w_errHit = 1'b1;
                    end else if (w_field == 16'd0) begin
                        w_msgDone = 1'b1;
                        w_natNext = (r_msgRemain <= 16'd1) ? c_TAIL : c_MLEN;
                    end else begin
                        w_natNext = c_MDATA;
                    end
                end
                c_MDATA: if (r_byteCnt == r_msgLen - 16'd1) begin
                    w_cntClr  = 1'b1;
                    w_msgDone = 1'b1;
                    w_natNext = (r_msgRemain <= 16'd1) ? c_TAIL : c_MLEN;
                end
                c_TAIL, c_SKIP: w_natNext = r_state;
                default: w_natNext = c_ETH;
            endcase
        end
        w_nextState = w_natNext;
        // Frame end: anything short of a finished (TAIL) or rejected (SKIP) frame is truncated.
        if (w_pValid && dataLastIn) begin
            w_nextState = c_ETH;
            w_cntClr    = 1'b1;
            w_truncErr  = (w_natNext != c_TAIL) && (w_natNext != c_SKIP);
        end else if (w_endNoByte) begin
            w_nextState = c_ETH;
            w_truncErr  = (r_state != c_TAIL) && (r_state != c_SKIP);
        end
    end

    always_comb begin
        w_msgValid = w_pValid && (r_state == c_MDATA);
        w_msgStart = w_msgValid && (r_byteCnt == 16'd0);
        w_msgLast  = w_msgValid && w_msgDone && !w_truncErr;
    end

    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            msgDataOut  <= '0;
            msgValidOut <= 1'b0;
            msgStartOut <= 1'b0;
            msgLastOut  <= 1'b0;
            seqNumOut   <= '0;
            dropOut     <= 1'b0;
            errOut      <= 1'b0;
            r_byteCnt   <= '0;
            r_msgRemain <= '0;
            r_msgLen    <= '0;
            r_prevByte  <= '0;
            r_hdrLen    <= '0;
            r_seq       <= '0;
        end else begin
            msgValidOut <= w_msgValid;
            msgStartOut <= w_msgStart;
            msgLastOut  <= w_msgLast;
            dropOut     <= w_dropHit;
            errOut      <= w_errHit || w_truncErr;
            if (w_msgValid) begin
                msgDataOut <= w_pByte;
                seqNumOut  <= r_seq;
            end
            if (w_endNoByte) begin
                r_byteCnt <= '0;
            end else if (w_pValid) begin
                r_byteCnt  <= w_cntClr ? 16'd0 : r_byteCnt + 16'd1;
                r_prevByte <= w_pByte;
                if (r_state == c_IP && r_byteCnt == 16'd0)
                    r_hdrLen <= {w_pByte[3:0], 2'b00};
                if (r_state == c_MOLD && r_byteCnt >= 16'd10 && r_byteCnt <= 16'd17)
                    r_seq <= {r_seq[55:0], w_pByte};
                if (r_state == c_MOLD && r_byteCnt == 16'd19)
                    r_msgRemain <= w_field;
                if (r_state == c_MLEN && r_byteCnt == 16'd1)
                    r_msgLen <= w_field;
                if (w_msgDone) begin
                    r_seq <= r_seq + 64'd1;
                    if (r_msgRemain != 16'd0)
                        r_msgRemain <= r_msgRemain - 16'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire
